rotater: RTL and testbench
==========================

ROTATER -- requirements
Module: rotater

Interface
REQ-001 Parameter: WIDTH, 12, accumulator width in bits; SHALL be even; all AC ports SHALL be WIDTH bits.
REQ-002 SYSCLK  input  1  system clock; all state SHALL change only on its rising edge.
REQ-003 RESET  input  1  one clock; reset is synchronous and active-high.
REQ-004 START  input  1  request to begin one rotate operation; sampled only in IDLE.
REQ-005 OP  input  3  {RAR, RAL, BSW} from OPR group 1 bits 8, 9, 10; sampled with START.
REQ-006 AC_IN  input  WIDTH  accumulator operand; sampled with START.
REQ-007 LINK_IN  input  1  link operand, driven by the link block's TO_ROTATER (CLL/CML already applied); sampled with START.
REQ-008 AC_OUT  output  WIDTH  rotated accumulator result; holds its value between operations.
REQ-009 LINK_OUT  output  1  rotated link result, wired to the link block's FROM_ROTATER; holds its value between operations.
REQ-010 AC_LD  output  1  one-cycle strobe; AC register SHALL load AC_OUT.
REQ-011 LINK_SET  output  1  one-cycle strobe, wired to the link block's SET; coincident with AC_LD.
REQ-012 BUSY  output  1  high in every state except IDLE.
REQ-013 DONE  output  1  one-cycle completion pulse, coincident with AC_LD.

Function
REQ-014 Internal 13-bit-equivalent register R = {L, AC} (WIDTH+1 bits) and a 2-bit step counter SHALL be maintained.
REQ-015 States: IDLE, SHIFT, WRITE; encoding held in the shared package.
REQ-016 IDLE + START=1: R <= {LINK_IN, AC_IN}, OP latched, counter <= step count (REQ-018); next state SHIFT if count>0, else WRITE.
REQ-017 START while BUSY SHALL be ignored; no queuing.
REQ-018 Step counts: RAL or RAR alone, BSW=0 -> 1; RAL or RAR alone, BSW=1 -> 2 (RTL/RTR); RAL=RAR=0, BSW=1 -> 1 (byte swap); RAL=RAR=0, BSW=0 -> 0 (pass-through); RAL=RAR=1 -> 0 (defined as pass-through regardless of BSW).
REQ-019 One step per SHIFT cycle: RAL: {L,AC} <= {AC[W-1], AC[W-2:0], L}; RAR: {L,AC} <= {AC[0], L, AC[W-1:1]}; BSW: AC <= {AC[W/2-1:0], AC[W-1:W/2]}, L unchanged.
REQ-020 SHIFT: counter decrements each step; after the step that brings it to 0, next state WRITE.
REQ-021 WRITE: AC_OUT/LINK_OUT SHALL present final R this cycle; AC_LD, LINK_SET, DONE high this cycle only; next state IDLE.
REQ-022 Latency: START sampled at edge N -> WRITE (strobes high) during cycle N+1+steps; pass-through 1 cycle, RAL/RAR/BSW 2, RTL/RTR 3.
REQ-023 A new START SHALL be accepted in the IDLE cycle immediately following WRITE (back-to-back throughput 1 op per steps+2 cycles).
REQ-024 Rotation SHALL be modular: WIDTH+1 successive RAL steps return original {L,AC}; no bit lost or duplicated.

Reset
REQ-025 RESET=1 at a rising edge: state IDLE, R=0, counter=0, AC_OUT=0, LINK_OUT=0, AC_LD=LINK_SET=DONE=BUSY=0.
REQ-026 RESET mid-operation SHALL abort without any AC_LD/LINK_SET pulse; RESET has priority over START.

Structure
REQ-027 Shared package SHALL hold state encoding, OP bit positions (RAR, RAL, BSW) and step-count constants.
REQ-028 One combinational sub-module rot_step SHALL implement a single RAL/RAR/BSW step on {L,AC}; rotater instantiates it once.

Verification
REQ-029 AC_IN=0o4001, LINK_IN=0, OP=RAL -> 2 cycles later AC_OUT=0o0002, LINK_OUT=1, AC_LD/LINK_SET/DONE one-cycle pulse.
REQ-030 AC_IN=0o0001, LINK_IN=1, OP=RTR -> 3 cycles later AC_OUT=0o6000, LINK_OUT=0; BUSY high for exactly 2 cycles before WRITE.
REQ-031 AC_IN=0o1234, LINK_IN=1, OP=BSW -> AC_OUT=0o3412, LINK_OUT=1; OP=RAL|RAR -> AC_OUT=0o1234 after 1 cycle.
REQ-032 START re-asserted during SHIFT of an RTL -> ignored, exactly one DONE; START held through WRITE -> second op starts next IDLE cycle.
REQ-033 RESET asserted during SHIFT of RTL -> no strobes, BUSY=0, AC_OUT=0 next cycle; 13 consecutive RAL ops restore AC=0o5252, L=1.

Source files
------------

// File: rtl/rotater_pkg.sv
// Shared definitions for the rotater: state encoding, OP bit positions and step counts.
// step_count() maps a {RAR, RAL, BSW} request onto the number of SHIFT cycles it needs.
package rotater_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam int OP_RAR = 2;
  localparam int OP_RAL = 1;
  localparam int OP_BSW = 0;

  localparam logic [1:0] STEPS_PASS   = 2'd0;
  localparam logic [1:0] STEPS_SINGLE = 2'd1;
  localparam logic [1:0] STEPS_DOUBLE = 2'd2;

  // RAL and RAR together is defined as a pass-through whatever BSW says.
  function automatic logic [1:0] step_count(input logic [2:0] op);
    logic [1:0] steps;
    steps = op[OP_BSW] ? STEPS_SINGLE : STEPS_PASS;
    if (op[OP_RAR] && op[OP_RAL]) begin
      steps = STEPS_PASS;
    end else if (op[OP_RAR] || op[OP_RAL]) begin
      steps = op[OP_BSW] ? STEPS_DOUBLE : STEPS_SINGLE;
    end
    return steps;
  endfunction

endpackage

// File: rtl/rotater_rot_step.sv
// One combinational rotate step on {L, AC}: RAL, RAR or byte swap.
// A rotate bit wins over BSW; BSW then means "rotate twice", sequenced by the caller.
module rot_step
  import rotater_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic [2:0]     op,
  input  logic [WIDTH:0] r_in,
  output logic [WIDTH:0] r_out
);

  always_comb begin
    r_out = r_in;
    if (op[OP_RAL] && !op[OP_RAR]) begin
      r_out = {r_in[WIDTH-1:0], r_in[WIDTH]};
    end else if (op[OP_RAR] && !op[OP_RAL]) begin
      r_out = {r_in[0], r_in[WIDTH:1]};
    end else if (op[OP_BSW] && !op[OP_RAL] && !op[OP_RAR]) begin
      r_out = {r_in[WIDTH], r_in[WIDTH/2-1:0], r_in[WIDTH-1:WIDTH/2]};
    end
  end

endmodule

// File: rtl/rotater.sv
// Multi-cycle AC/link rotater: latches operands on START, steps once per SHIFT cycle,
// then strobes the result out in a single WRITE cycle. START is ignored while BUSY.
module rotater
  import rotater_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             SYSCLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] AC_IN,
  input  logic             LINK_IN,
  output logic [WIDTH-1:0] AC_OUT,
  output logic             LINK_OUT,
  output logic             AC_LD,
  output logic             LINK_SET,
  output logic             BUSY,
  output logic             DONE
);

  state_t         state;
  logic [WIDTH:0] r;
  logic [2:0]     op_q;
  logic [1:0]     cnt;
  logic [WIDTH:0] r_next;
  logic [1:0]     start_steps;

  assign start_steps = step_count(OP);

  rot_step #(.WIDTH(WIDTH)) u_rot_step (
    .op    (op_q),
    .r_in  (r),
    .r_out (r_next)
  );

  // Outputs are loaded on the edge that enters WRITE so they hold between operations.
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      r        <= '0;
      op_q     <= '0;
      cnt      <= '0;
      AC_OUT   <= '0;
      LINK_OUT <= 1'b0;
      AC_LD    <= 1'b0;
      LINK_SET <= 1'b0;
      DONE     <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      AC_LD    <= 1'b0;
      LINK_SET <= 1'b0;
      DONE     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            r    <= {LINK_IN, AC_IN};
            op_q <= OP;
            cnt  <= start_steps;
            BUSY <= 1'b1;
            if (start_steps == STEPS_PASS) begin
              state    <= ST_WRITE;
              AC_OUT   <= AC_IN;
              LINK_OUT <= LINK_IN;
              AC_LD    <= 1'b1;
              LINK_SET <= 1'b1;
              DONE     <= 1'b1;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          r   <= r_next;
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            state    <= ST_WRITE;
            AC_OUT   <= r_next[WIDTH-1:0];
            LINK_OUT <= r_next[WIDTH];
            AC_LD    <= 1'b1;
            LINK_SET <= 1'b1;
            DONE     <= 1'b1;
          end
        end
        ST_WRITE: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotater.sv
// Scoreboard bench for rotater: driver pushes model results, negedge monitor pops on DONE.
module tb_rotater;
  localparam int W = 12;

  logic         SYSCLK = 1'b0;
  logic         RESET, START, LINK_IN;
  logic [2:0]   OP;
  logic [W-1:0] AC_IN;
  logic [W-1:0] AC_OUT;
  logic         LINK_OUT, AC_LD, LINK_SET, BUSY, DONE;

  always #5 SYSCLK = ~SYSCLK;

  rotater #(.WIDTH(W)) dut (
    .SYSCLK(SYSCLK), .RESET(RESET), .START(START), .OP(OP), .AC_IN(AC_IN),
    .LINK_IN(LINK_IN), .AC_OUT(AC_OUT), .LINK_OUT(LINK_OUT), .AC_LD(AC_LD),
    .LINK_SET(LINK_SET), .BUSY(BUSY), .DONE(DONE)
  );

  typedef struct {
    logic [W-1:0] ac;
    logic         link;
    int           sample_edge;
    int           steps;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0, checks = 0, cyc = 0, busy_run = 0, done_cnt = 0;
  bit   mon_en = 0;

  always @(posedge SYSCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: 13-bit ring rotation by arithmetic, byte swap as 6-bit digit exchange.
  function automatic logic [W:0] model(input logic [2:0] op, input logic [W:0] v);
    logic [W:0] x;
    int         ac, half;
    bit         rar, ral, bsw;
    rar = op[2]; ral = op[1]; bsw = op[0];
    x = v;
    if (ral && rar) return v;
    if (ral || rar) begin
      for (int i = 0; i < (bsw ? 2 : 1); i++)
        x = ral ? ((x << 1) | (x >> W)) : ((x >> 1) | (x << W));
      return x;
    end
    if (bsw) begin
      half = 1 << (W / 2);
      ac = int'(v[W-1:0]);
      ac = (ac % half) * half + (ac / half);
      x = {v[W], ac[W-1:0]};
    end
    return x;
  endfunction

  function automatic int steps_of(input logic [2:0] op);
    if (op[2] && op[1]) return 0;
    if (op[2] || op[1]) return op[0] ? 2 : 1;
    return op[0] ? 1 : 0;
  endfunction

  always @(negedge SYSCLK) begin
    if (mon_en) begin
      if (DONE || AC_LD || LINK_SET) begin
        check("strobes_busy", {28'd0, AC_LD, LINK_SET, DONE, BUSY}, 32'hF);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got DONE with ac=%0o expected no completion", AC_OUT);
        end else begin
          mon_e = sb.pop_front();
          check("ac_out", {20'd0, AC_OUT}, {20'd0, mon_e.ac});
          check("link_out", {31'd0, LINK_OUT}, {31'd0, mon_e.link});
          check("latency", cyc - mon_e.sample_edge, mon_e.steps);
          check("busy_cycles", busy_run, mon_e.steps);
        end
        done_cnt++;
        busy_run = 0;
      end else if (BUSY) begin
        busy_run++;
      end else begin
        busy_run = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (BUSY !== 1'b0 && n < 50) begin
      @(posedge SYSCLK); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: BUSY=%b expected 0 within 50 cycles", BUSY);
    end
  endtask

  task automatic push_exp(input logic [2:0] op, input logic [W-1:0] ac, input logic l, input int edge_no);
    exp_t       e;
    logic [W:0] r;
    r = model(op, {l, ac});
    e.ac = r[W-1:0];
    e.link = r[W];
    e.sample_edge = edge_no;
    e.steps = steps_of(op);
    sb.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] ac, input logic l);
    wait_idle();
    OP = op; AC_IN = ac; LINK_IN = l; START = 1'b1;
    push_exp(op, ac, l, cyc + 1);
    @(posedge SYSCLK); #1;
    START = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge SYSCLK); #1;
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding expected 0", sb.size());
      sb.delete();
    end
    wait_idle();
  endtask

  initial begin
    logic [W-1:0] cur_ac;
    logic         cur_l;
    int           d0;
    RESET = 1'b1; START = 1'b0; OP = '0; AC_IN = '0; LINK_IN = 1'b0;
    repeat (2) @(posedge SYSCLK);
    @(negedge SYSCLK);
    check("reset_outputs", {17'd0, AC_OUT, LINK_OUT, AC_LD, LINK_SET, BUSY, DONE}, 32'd0);
    @(posedge SYSCLK); #1;
    RESET = 1'b0;
    mon_en = 1;

    issue(3'b010, 12'o4001, 1'b0);   // RAL
    issue(3'b101, 12'o0001, 1'b1);   // RTR
    issue(3'b001, 12'o1234, 1'b1);   // BSW
    issue(3'b110, 12'o1234, 1'b1);   // RAL|RAR pass-through
    issue(3'b111, 12'o7070, 1'b0);
    issue(3'b000, 12'o0707, 1'b1);
    issue(3'b011, 12'o4000, 1'b1);   // RTL
    drain();

    // START pulsed again during SHIFT of an RTL must be ignored.
    d0 = done_cnt;
    OP = 3'b011; AC_IN = 12'o2525; LINK_IN = 1'b0; START = 1'b1;
    push_exp(3'b011, 12'o2525, 1'b0, cyc + 1);
    @(posedge SYSCLK); #1;
    OP = 3'b000; AC_IN = 12'o7777;
    @(posedge SYSCLK); #1;
    START = 1'b0;
    drain();
    check("ignored_start_dones", done_cnt - d0, 1);

    // START held through WRITE: second RAL sampled in the next IDLE cycle.
    d0 = done_cnt;
    OP = 3'b010; AC_IN = 12'o0123; LINK_IN = 1'b1; START = 1'b1;
    push_exp(3'b010, 12'o0123, 1'b1, cyc + 1);
    push_exp(3'b010, 12'o0123, 1'b1, cyc + 4);
    repeat (4) @(posedge SYSCLK);
    #1 START = 1'b0;
    drain();
    check("held_start_dones", done_cnt - d0, 2);

    // Reset during SHIFT aborts with no strobes and clears the outputs.
    issue(3'b010, 12'o4001, 1'b0);
    drain();
    d0 = done_cnt;
    OP = 3'b011; AC_IN = 12'o1357; LINK_IN = 1'b1; START = 1'b1;
    @(posedge SYSCLK); #1;
    START = 1'b0; RESET = 1'b1;
    @(posedge SYSCLK); #1;
    check("abort_state", {18'd0, AC_OUT, LINK_OUT, AC_LD, LINK_SET, BUSY}, 32'd0);
    RESET = 1'b0;
    repeat (5) @(posedge SYSCLK);
    #1 check("abort_no_done", done_cnt - d0, 0);

    // Thirteen chained RAL operations return the original {L, AC}.
    cur_ac = 12'o5252; cur_l = 1'b1;
    for (int i = 0; i < W + 1; i++) begin
      issue(3'b010, cur_ac, cur_l);
      wait_idle();
      cur_ac = AC_OUT; cur_l = LINK_OUT;
    end
    drain();
    check("modular_ac", {20'd0, AC_OUT}, {20'd0, 12'o5252});
    check("modular_link", {31'd0, LINK_OUT}, 32'd1);

    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge SYSCLK); #1;
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
